// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle for nibble_serial_adder.
// Port sub exists only when NIBBLE_SERIAL_ADDER_SUB_EN is defined.
`timescale 1ns/1ps
interface nibble_serial_adder_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
   logic            sub;
`endif
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result;
   logic            cout;
   logic            overflow;
   logic            zero;

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
   modport master (
      output in_valid, a, b, sub, out_ready,
      input  in_ready, out_valid, result, cout, overflow, zero
   );
   modport slave (
      input  in_valid, a, b, sub, out_ready,
      output in_ready, out_valid, result, cout, overflow, zero
   );
`else
   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, result, cout, overflow, zero
   );
   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, result, cout, overflow, zero
   );
`endif
endinterface

// File: rtl/nibble_serial_adder.sv
// Bit-serial-by-nibble adder: one 4-bit carry-lookahead cell reused XLEN/4 times, LSB nibble first.
// Optional subtract mode is enabled with the NIBBLE_SERIAL_ADDER_SUB_EN macro (adds port sub).
//
//   state | meaning
//   IDLE  | waiting for operands, in_ready = 1
//   RUN   | one nibble summed per cycle, idx_q selects the nibble
//   DONE  | result held, out_valid = 1 until out_ready
`timescale 1ns/1ps
module nsa_cla4 (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  logic       cin_i,
   output logic [3:0] sum_o,
   output logic       cout_o
);
   logic [3:0] g;
   logic [3:0] p;
   logic [4:0] c;

   assign g = a_i & b_i;
   assign p = a_i ^ b_i;

   assign c[0] = cin_i;
   assign c[1] = g[0] | (p[0] & cin_i);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_i);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & cin_i);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin_i);

   assign sum_o  = p ^ c[3:0];
   assign cout_o = c[4];
endmodule

module nibble_serial_adder #(
   parameter int XLEN = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   nibble_serial_adder_if.slave bus
);
   localparam int NIB  = XLEN / 4;
   localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

   if ((XLEN % 4) != 0 || XLEN < 8) begin : g_bad_xlen
      $error("nibble_serial_adder: XLEN must be a multiple of 4 and at least 8");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [IDXW-1:0]   idx_q, idx_d;
   logic              carry_q, carry_d;
   logic [XLEN-1:0]   a_q, a_d;
   logic [XLEN-1:0]   b_q, b_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic              cout_q, cout_d;
   logic              ovf_q, ovf_d;

   logic [XLEN-1:0]   b_in;
   logic              cin_in;
   logic [3:0]        nib_a;
   logic [3:0]        nib_b;
   logic [3:0]        nib_sum;
   logic              nib_cout;
   logic              last_nib;

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
   // Two's-complement subtract: invert B and inject the +1 as carry-in.
   assign b_in   = bus.sub ? ~bus.b : bus.b;
   assign cin_in = bus.sub;
`else
   assign b_in   = bus.b;
   assign cin_in = 1'b0;
`endif

   assign nib_a    = a_q[4*idx_q +: 4];
   assign nib_b    = b_q[4*idx_q +: 4];
   assign last_nib = (idx_q == IDXW'(NIB - 1));

   nsa_cla4 u_cla (
      .a_i    (nib_a),
      .b_i    (nib_b),
      .cin_i  (carry_q),
      .sum_o  (nib_sum),
      .cout_o (nib_cout)
   );

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      carry_d  = carry_q;
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               a_d     = bus.a;
               b_d     = b_in;
               carry_d = cin_in;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            result_d[4*idx_q +: 4] = nib_sum;
            carry_d = nib_cout;
            idx_d   = idx_q + 1'b1;
            if (last_nib) begin
               // nib_sum[3] is the final result MSB, available only in this cycle.
               cout_d  = nib_cout;
               ovf_d   = (a_q[XLEN-1] == b_q[XLEN-1]) && (nib_sum[3] != a_q[XLEN-1]);
               idx_d   = '0;
               state_d = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         carry_q  <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         carry_q  <= carry_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.result    = result_q;
   assign bus.cout      = cout_q;
   assign bus.overflow  = ovf_q;
   assign bus.zero      = (result_q == '0);
endmodule
